axi_read_arbiter: RTL and testbench
===================================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Parameters
REQ-001 BusWidth, default 32, width of ARADDR and RDATA.
REQ-002 tagbits, default 1, width of ARID and RID.
REQ-003 DEPTH, default 4, maximum outstanding read bursts; power of two, 2..16.

Interface
REQ-004 ACLK  input  1  single clock; all logic SHALL operate on its rising edge.
REQ-005 ARESET  input  1  synchronous, active-high reset.
REQ-006 M0_ARID/M1_ARID  input  tagbits  per-master read ID.
REQ-007 M0_ARADDR/M1_ARADDR  input  BusWidth  per-master start address.
REQ-008 M0_ARLEN/M1_ARLEN  input  4  per-master beat count minus one.
REQ-009 M0_ARSIZE, M0_ARBURST/M1_ARSIZE, M1_ARBURST  input  2 each  per-master size and burst type.
REQ-010 M0_ARVALID/M1_ARVALID  input  1  per-master request valid.
REQ-011 M0_ARREADY/M1_ARREADY  output  1  grant and accept to the master.
REQ-012 S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST  output  tagbits/BusWidth/4/2/2  registered AR payload to the slave.
REQ-013 S_ARVALID  output  1  slave AR valid.
REQ-014 S_ARREADY  input  1  slave AR ready.
REQ-015 S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID  input  tagbits/BusWidth/2/1/1  slave R channel.
REQ-016 S_RREADY  output  1  slave R ready.
REQ-017 M0_RID, M0_RDATA, M0_RRESP, M0_RLAST/M1_RID, M1_RDATA, M1_RRESP, M1_RLAST  output  tagbits/BusWidth/2/1  R payload, copied straight through from S_R* to both masters.
REQ-018 M0_RVALID/M1_RVALID  output  1  routed R valid.
REQ-019 M0_RREADY/M1_RREADY  input  1  master R ready.

Function
REQ-020 The AR FSM SHALL have two states: IDLE and ADDR.
REQ-021 In IDLE, with count<DEPTH and any Mx_ARVALID=1, the block SHALL grant exactly one master.
  - If only one master requests, that master is granted.
  - If both request, the master not granted last is granted.
REQ-022 In the grant cycle, the block SHALL:
  - drive Mg_ARREADY=1 combinationally (the master handshake completes in that cycle);
  - register Mg's payload into S_AR*;
  - set S_ARVALID=1 on the next edge;
  - move to ADDR.
REQ-023 Mx_ARREADY SHALL be 0 in ADDR, when count==DEPTH, and for the non-granted master.
REQ-024 In ADDR, S_ARVALID and S_AR* SHALL hold stable until S_ARREADY=1.
REQ-025 On the S_ARREADY=1 edge, the block SHALL:
  - clear S_ARVALID;
  - push the grant index g into the owner FIFO (DEPTH entries);
  - set last_grant=g;
  - return to IDLE.
REQ-026 Latency from Mx_ARVALID to S_ARVALID SHALL be 1 cycle, and AR throughput SHALL be at most one burst per 2 cycles.
REQ-027 R routing: with the FIFO non-empty and head owner h:
  - Mh_RVALID = S_RVALID;
  - the other master's RVALID = 0;
  - S_RREADY = Mh_RREADY.
REQ-028 With the FIFO empty, S_RREADY and both Mx_RVALID SHALL be 0.
REQ-029 A beat with S_RVALID & S_RREADY & S_RLAST SHALL pop the FIFO head.
REQ-030 count SHALL be the owner-FIFO occupancy (0..DEPTH).
  - Push only: increment.
  - Pop only: decrement.
  - Push and pop in the same cycle: unchanged, with FIFO order preserved.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH.
REQ-032 count==DEPTH SHALL block new grants, and the grant SHALL resume in the cycle after a pop makes count<DEPTH.
REQ-033 A master deasserting ARVALID before its grant SHALL have no effect, because no payload is captured.

Reset
REQ-034 While ARESET=1 at an edge, the block SHALL:
  - set state=IDLE and S_ARVALID=0;
  - clear S_AR* to 0;
  - set count=0 and clear the FIFO pointers;
  - set last_grant=1, so M0 wins the first tie.
REQ-035 While ARESET=1, Mx_ARREADY, Mx_RVALID and S_RREADY SHALL be 0.
REQ-036 Reset mid-operation SHALL abort ADDR and discard all outstanding owners, with no pending handshake completed.

Verification
REQ-037 Single request: M0 requests ARADDR=0x100, ARLEN=3, S_ARREADY held 1.
  - M0_ARREADY is 1 in cycle 0.
  - S_ARVALID is 1 in cycle 1 with ADDR=0x100.
  - 4 R beats are routed to M0 only.
  - count returns to 0 after RLAST.
REQ-038 Tie and alternation: both masters request continuously.
  - Grants are M0, M1, M0, M1.
  - The R bursts are returned to owners in the same order.
REQ-039 Slave backpressure: S_ARREADY=0 for 5 cycles.
  - S_ARVALID and S_ARADDR stay stable.
  - Both Mx_ARREADY stay 0.
  - On the S_ARREADY=1 edge, count becomes 1.
REQ-040 Full condition: 4 grants with no R traffic.
  - count==4 and no 5th grant.
  - One RLAST beat, then the 5th grant occurs in the following cycle.
REQ-041 Push and pop in the same cycle leave count unchanged and routing correct.
  - Master R backpressure: M1_RREADY=0 stalls S_RREADY while M0_RVALID stays 0.
REQ-042 Mid-burst reset: ARESET during ADDR with 2 outstanding clears S_ARVALID and count to 0, and the first tie after release grants M0.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
// Two-master to one-slave AXI read arbiter.
//  - AR channel: a two-state FSM (IDLE/ADDR) grants one master at a time,
//    alternating on ties, and registers the winning payload onto S_AR*.
//    At most one burst is accepted every two cycles.
//  - R channel: an owner FIFO records the winning master for each burst the
//    slave accepted. The head entry steers S_RVALID and S_RREADY to and from
//    that master. A beat with RLAST retires the head entry.
// Ports:
//  ACLK, ARESET          clock and synchronous active-high reset
//  Mx_AR*                per-master AR request inputs and Mx_ARREADY grant
//  S_AR*                 registered AR payload and valid toward the slave, plus S_ARREADY
//  S_R*, S_RREADY        slave R channel
//  Mx_R*                 R payload copied to both masters, with routed Mx_RVALID
//                        and the masters' Mx_RREADY
module axi_read_arbiter #(
  parameter int BusWidth = 32,
  parameter int tagbits  = 1,
  parameter int DEPTH    = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [tagbits-1:0]  M0_ARID,
  input  logic [BusWidth-1:0] M0_ARADDR,
  input  logic [3:0]          M0_ARLEN,
  input  logic [1:0]          M0_ARSIZE,
  input  logic [1:0]          M0_ARBURST,
  input  logic                M0_ARVALID,
  output logic                M0_ARREADY,
  input  logic [tagbits-1:0]  M1_ARID,
  input  logic [BusWidth-1:0] M1_ARADDR,
  input  logic [3:0]          M1_ARLEN,
  input  logic [1:0]          M1_ARSIZE,
  input  logic [1:0]          M1_ARBURST,
  input  logic                M1_ARVALID,
  output logic                M1_ARREADY,
  output logic [tagbits-1:0]  S_ARID,
  output logic [BusWidth-1:0] S_ARADDR,
  output logic [3:0]          S_ARLEN,
  output logic [1:0]          S_ARSIZE,
  output logic [1:0]          S_ARBURST,
  output logic                S_ARVALID,
  input  logic                S_ARREADY,
  input  logic [tagbits-1:0]  S_RID,
  input  logic [BusWidth-1:0] S_RDATA,
  input  logic [1:0]          S_RRESP,
  input  logic                S_RLAST,
  input  logic                S_RVALID,
  output logic                S_RREADY,
  output logic [tagbits-1:0]  M0_RID,
  output logic [BusWidth-1:0] M0_RDATA,
  output logic [1:0]          M0_RRESP,
  output logic                M0_RLAST,
  output logic                M0_RVALID,
  input  logic                M0_RREADY,
  output logic [tagbits-1:0]  M1_RID,
  output logic [BusWidth-1:0] M1_RDATA,
  output logic [1:0]          M1_RRESP,
  output logic                M1_RLAST,
  output logic                M1_RVALID,
  input  logic                M1_RREADY
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ADDR = 1'b1;

  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0] COUNT_ZERO = CW'(0);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  logic [0:0]          state_q, state_d;
  logic                grant_q, grant_d;          // owner of the AR held in ADDR
  logic                last_grant_q, last_grant_d;
  logic [tagbits-1:0]  s_arid_q, s_arid_d;
  logic [BusWidth-1:0] s_araddr_q, s_araddr_d;
  logic [3:0]          s_arlen_q, s_arlen_d;
  logic [1:0]          s_arsize_q, s_arsize_d;
  logic [1:0]          s_arburst_q, s_arburst_d;
  logic                s_arvalid_q, s_arvalid_d;
  logic [CW-1:0]       count_q, count_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]    owner_q, owner_d;

  logic can_grant_s;
  logic sel_s;
  logic grant_fire_s;
  logic head_s;
  logic route_en_s;
  logic push_s;
  logic pop_s;

  // Arbitration: pick the requester, alternating against the last accepted burst on a tie.
  always_comb begin
    can_grant_s  = 1'b0;
    sel_s        = 1'b0;
    if (!ARESET && (state_q == IDLE) && (count_q < COUNT_FULL)) begin
      can_grant_s = 1'b1;
    end else begin
      can_grant_s = 1'b0;
    end
    if (M0_ARVALID && M1_ARVALID) begin
      sel_s = ~last_grant_q;
    end else if (M0_ARVALID) begin
      sel_s = 1'b0;
    end else begin
      sel_s = 1'b1;
    end
    grant_fire_s = can_grant_s & (M0_ARVALID | M1_ARVALID);
  end

  assign M0_ARREADY = grant_fire_s & ~sel_s;
  assign M1_ARREADY = grant_fire_s &  sel_s;

  // R steering: the FIFO head owns the slave R channel until its RLAST beat.
  always_comb begin
    head_s     = owner_q[rd_ptr_q];
    route_en_s = !ARESET && (count_q != COUNT_ZERO);
    M0_RVALID  = route_en_s & ~head_s & S_RVALID;
    M1_RVALID  = route_en_s &  head_s & S_RVALID;
    if (head_s) begin
      S_RREADY = route_en_s & M1_RREADY;
    end else begin
      S_RREADY = route_en_s & M0_RREADY;
    end
    pop_s  = S_RVALID & S_RREADY & S_RLAST;
    push_s = (state_q == ADDR) & S_ARREADY;
  end

  assign M0_RID   = S_RID;
  assign M0_RDATA = S_RDATA;
  assign M0_RRESP = S_RRESP;
  assign M0_RLAST = S_RLAST;
  assign M1_RID   = S_RID;
  assign M1_RDATA = S_RDATA;
  assign M1_RRESP = S_RRESP;
  assign M1_RLAST = S_RLAST;

  assign S_ARID    = s_arid_q;
  assign S_ARADDR  = s_araddr_q;
  assign S_ARLEN   = s_arlen_q;
  assign S_ARSIZE  = s_arsize_q;
  assign S_ARBURST = s_arburst_q;
  assign S_ARVALID = s_arvalid_q;

  // AR FSM next state: capture the winner's payload on grant, hold it until the slave accepts.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s_arid_d     = s_arid_q;
    s_araddr_d   = s_araddr_q;
    s_arlen_d    = s_arlen_q;
    s_arsize_d   = s_arsize_q;
    s_arburst_d  = s_arburst_q;
    s_arvalid_d  = s_arvalid_q;
    case (state_q)
      IDLE: begin
        if (grant_fire_s) begin
          state_d     = ADDR;
          s_arvalid_d = 1'b1;
          grant_d     = sel_s;
          if (sel_s) begin
            s_arid_d    = M1_ARID;
            s_araddr_d  = M1_ARADDR;
            s_arlen_d   = M1_ARLEN;
            s_arsize_d  = M1_ARSIZE;
            s_arburst_d = M1_ARBURST;
          end else begin
            s_arid_d    = M0_ARID;
            s_araddr_d  = M0_ARADDR;
            s_arlen_d   = M0_ARLEN;
            s_arsize_d  = M0_ARSIZE;
            s_arburst_d = M0_ARBURST;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (S_ARREADY) begin
          state_d      = IDLE;
          s_arvalid_d  = 1'b0;
          last_grant_d = grant_q;
        end else begin
          state_d = ADDR;
        end
      end
      default: begin
        state_d     = IDLE;
        s_arvalid_d = 1'b0;
      end
    endcase
  end

  // Owner FIFO next state: a push and a pop in the same cycle leave the occupancy unchanged.
  always_comb begin
    owner_d  = owner_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      owner_d[wr_ptr_q] = grant_q;
      wr_ptr_d          = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset; reset drops any pending AR and all owners.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      s_arid_q     <= {tagbits{1'b0}};
      s_araddr_q   <= {BusWidth{1'b0}};
      s_arlen_q    <= 4'd0;
      s_arsize_q   <= 2'd0;
      s_arburst_q  <= 2'd0;
      s_arvalid_q  <= 1'b0;
      count_q      <= COUNT_ZERO;
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      owner_q      <= {DEPTH{1'b0}};
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      s_arid_q     <= s_arid_d;
      s_araddr_q   <= s_araddr_d;
      s_arlen_q    <= s_arlen_d;
      s_arsize_q   <= s_arsize_d;
      s_arburst_q  <= s_arburst_d;
      s_arvalid_q  <= s_arvalid_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      owner_q      <= owner_d;
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
module tb_axi_read_arbiter;
  localparam int BW    = 32;
  localparam int TB    = 1;
  localparam int DEPTH = 4;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [TB-1:0] M0_ARID, M1_ARID, S_ARID, S_RID, M0_RID, M1_RID;
  logic [BW-1:0] M0_ARADDR, M1_ARADDR, S_ARADDR, S_RDATA, M0_RDATA, M1_RDATA;
  logic [3:0]    M0_ARLEN, M1_ARLEN, S_ARLEN;
  logic [1:0]    M0_ARSIZE, M1_ARSIZE, S_ARSIZE, M0_ARBURST, M1_ARBURST, S_ARBURST;
  logic [1:0]    S_RRESP, M0_RRESP, M1_RRESP;
  logic          M0_ARVALID, M1_ARVALID, M0_ARREADY, M1_ARREADY;
  logic          S_ARVALID, S_ARREADY, S_RLAST, S_RVALID, S_RREADY;
  logic          M0_RLAST, M1_RLAST, M0_RVALID, M1_RVALID, M0_RREADY, M1_RREADY;

  axi_read_arbiter #(.BusWidth(BW), .tagbits(TB), .DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .M0_ARID(M0_ARID), .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_ARSIZE(M0_ARSIZE),
    .M0_ARBURST(M0_ARBURST), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
    .M1_ARID(M1_ARID), .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN), .M1_ARSIZE(M1_ARSIZE),
    .M1_ARBURST(M1_ARBURST), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
    .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
    .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .M0_RID(M0_RID), .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP), .M0_RLAST(M0_RLAST),
    .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
    .M1_RID(M1_RID), .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP), .M1_RLAST(M1_RLAST),
    .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // owners: masters whose bursts the slave accepted, oldest first.
  // pend: an AR granted but not yet accepted by the slave, with its payload.
  int            owners[$];
  bit            pend       = 1'b0;
  int            pend_owner = 0;
  int            last_g     = 1;
  logic [TB-1:0] p_id;
  logic [BW-1:0] p_addr;
  logic [3:0]    p_len;
  logic [1:0]    p_size, p_burst;

  always @(negedge ACLK) begin : model
    bit ne, can, e_ar0, e_ar1, e_rv0, e_rv1, e_srr, pop, push;
    int g, h;
    if (chk_en) begin
      ne  = owners.size() > 0;
      h   = ne ? owners[0] : 0;
      can = !ARESET && !pend && (owners.size() < DEPTH);
      if (M0_ARVALID && M1_ARVALID) g = 1 - last_g;
      else if (M0_ARVALID)          g = 0;
      else                          g = 1;
      e_ar0 = can && M0_ARVALID && (g == 0);
      e_ar1 = can && M1_ARVALID && (g == 1);
      e_rv0 = !ARESET && ne && (h == 0) && S_RVALID;
      e_rv1 = !ARESET && ne && (h == 1) && S_RVALID;
      e_srr = !ARESET && ne && ((h == 0) ? M0_RREADY : M1_RREADY);

      chk("m0_arready", M0_ARREADY, e_ar0);
      chk("m1_arready", M1_ARREADY, e_ar1);
      chk("m0_rvalid", M0_RVALID, e_rv0);
      chk("m1_rvalid", M1_RVALID, e_rv1);
      chk("s_rready", S_RREADY, e_srr);
      chk("s_arvalid", S_ARVALID, pend);
      if (pend)
        chk("s_ar_payload", {S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST},
            {p_id, p_addr, p_len, p_size, p_burst});
      chk("m0_r_payload", {M0_RID, M0_RDATA, M0_RRESP, M0_RLAST}, {S_RID, S_RDATA, S_RRESP, S_RLAST});
      chk("m1_r_payload", {M1_RID, M1_RDATA, M1_RRESP, M1_RLAST}, {S_RID, S_RDATA, S_RRESP, S_RLAST});
      chk("count", dut.count_q, owners.size());

      if (ARESET) begin
        owners.delete();
        pend   = 1'b0;
        last_g = 1;
      end else begin
        pop  = ne && S_RVALID && e_srr && S_RLAST;
        push = pend && S_ARREADY;
        if (pop) void'(owners.pop_front());
        if (push) begin
          owners.push_back(pend_owner);
          last_g = pend_owner;
          pend   = 1'b0;
        end
        if (e_ar0 || e_ar1) begin
          pend       = 1'b1;
          pend_owner = g;
          if (g == 1) begin
            p_id = M1_ARID; p_addr = M1_ARADDR; p_len = M1_ARLEN; p_size = M1_ARSIZE; p_burst = M1_ARBURST;
          end else begin
            p_id = M0_ARID; p_addr = M0_ARADDR; p_len = M0_ARLEN; p_size = M0_ARSIZE; p_burst = M0_ARBURST;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic mid();
    @(negedge ACLK);
  endtask

  task automatic idle_in();
    M0_ARVALID = 1'b0; M1_ARVALID = 1'b0;
    M0_ARID = 1'b0; M1_ARID = 1'b1;
    M0_ARADDR = 32'h0; M1_ARADDR = 32'h0;
    M0_ARLEN = 4'd0; M1_ARLEN = 4'd0;
    M0_ARSIZE = 2'd2; M1_ARSIZE = 2'd2;
    M0_ARBURST = 2'd1; M1_ARBURST = 2'd1;
    S_ARREADY = 1'b0;
    S_RVALID = 1'b0; S_RLAST = 1'b0; S_RID = 1'b0; S_RDATA = 32'h0; S_RRESP = 2'd0;
    M0_RREADY = 1'b1; M1_RREADY = 1'b1;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    idle_in();
    cyc();
    cyc();
    ARESET = 1'b0;
  endtask

  initial begin
    int gseq[$];
    int own;

    // reset state, with requests and R traffic present during reset
    idle_in();
    ARESET = 1'b1;
    cyc();
    chk_en = 1'b1;
    M0_ARVALID = 1'b1; M1_ARVALID = 1'b1; S_RVALID = 1'b1;
    mid();
    chk("rst_m0_arready", M0_ARREADY, 1'b0);
    chk("rst_s_rready", S_RREADY, 1'b0);
    chk("rst_s_arvalid", S_ARVALID, 1'b0);
    chk("rst_s_araddr", S_ARADDR, 32'h0);
    chk("rst_count", dut.count_q, 0);

    // single request
    do_reset();
    M0_ARVALID = 1'b1; M0_ARADDR = 32'h100; M0_ARLEN = 4'd3; S_ARREADY = 1'b1;
    mid();
    chk("t1_m0_arready", M0_ARREADY, 1'b1);
    chk("t1_m1_arready", M1_ARREADY, 1'b0);
    cyc(); M0_ARVALID = 1'b0;
    mid();
    chk("t1_s_arvalid", S_ARVALID, 1'b1);
    chk("t1_s_araddr", S_ARADDR, 32'h100);
    chk("t1_s_arlen", S_ARLEN, 4'd3);
    cyc(); S_ARREADY = 1'b0;
    mid();
    chk("t1_count_after_accept", dut.count_q, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(); S_RVALID = 1'b1; S_RLAST = (i == 3); S_RDATA = $urandom;
      mid();
      chk("t1_beat_m0", M0_RVALID, 1'b1);
      chk("t1_beat_m1", M1_RVALID, 1'b0);
    end
    cyc(); S_RVALID = 1'b0; S_RLAST = 1'b0;
    mid();
    chk("t1_count_after_rlast", dut.count_q, 0);

    // tie and alternation
    do_reset();
    M0_ARVALID = 1'b1; M1_ARVALID = 1'b1; M0_ARADDR = 32'hA0; M1_ARADDR = 32'hB0; S_ARREADY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mid();
      if (M0_ARREADY) gseq.push_back(0);
      if (M1_ARREADY) gseq.push_back(1);
      cyc();
    end
    M0_ARVALID = 1'b0; M1_ARVALID = 1'b0;
    chk("t2_ngrants", gseq.size(), 4);
    for (int k = 0; k < gseq.size() && k < 4; k++) chk("t2_grant_order", gseq[k], k % 2);
    for (int i = 0; i < 4; i++) begin
      S_RVALID = 1'b1; S_RLAST = 1'b1; S_RDATA = $urandom;
      mid();
      own = M0_RVALID ? 0 : (M1_RVALID ? 1 : 9);
      chk("t2_r_owner", own, i % 2);
      cyc();
    end
    S_RVALID = 1'b0; S_RLAST = 1'b0;

    // slave AR backpressure
    do_reset();
    M0_ARVALID = 1'b1; M0_ARADDR = 32'h200;
    mid();
    chk("t3_grant", M0_ARREADY, 1'b1);
    cyc(); M0_ARADDR = 32'h300; M1_ARVALID = 1'b1; M1_ARADDR = 32'h400;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("t3_s_arvalid", S_ARVALID, 1'b1);
      chk("t3_s_araddr", S_ARADDR, 32'h200);
      chk("t3_ar_blocked", {M0_ARREADY, M1_ARREADY}, 2'b00);
      cyc();
    end
    S_ARREADY = 1'b1; M0_ARVALID = 1'b0; M1_ARVALID = 1'b0;
    cyc(); S_ARREADY = 1'b0;
    mid();
    chk("t3_count", dut.count_q, 1);
    chk("t3_s_arvalid_clr", S_ARVALID, 1'b0);

    // full FIFO, release by one RLAST, then push+pop and master R backpressure
    do_reset();
    M0_ARVALID = 1'b1; M1_ARVALID = 1'b1; S_ARREADY = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("t4_full_count", dut.count_q, 4);
      chk("t4_no_grant", {M0_ARREADY, M1_ARREADY}, 2'b00);
      cyc();
    end
    S_RVALID = 1'b1; S_RLAST = 1'b1;
    mid();
    chk("t4_pop_cycle_no_grant", {M0_ARREADY, M1_ARREADY}, 2'b00);
    chk("t4_head_m0", M0_RVALID, 1'b1);
    cyc(); S_RVALID = 1'b0; S_RLAST = 1'b0;
    mid();
    chk("t4_fifth_grant", {M0_ARREADY, M1_ARREADY}, 2'b10);
    cyc(); M0_ARVALID = 1'b0; M1_ARVALID = 1'b0; S_RVALID = 1'b1; S_RLAST = 1'b1;
    mid();
    chk("t5_head_m1", {M0_RVALID, M1_RVALID}, 2'b01);
    cyc(); S_RVALID = 1'b0; S_RLAST = 1'b0; S_ARREADY = 1'b0;
    mid();
    chk("t5_push_pop_count", dut.count_q, 3);
    cyc(); S_RVALID = 1'b1; S_RLAST = 1'b1;
    mid();
    cyc(); S_RLAST = 1'b0; M1_RREADY = 1'b0;
    mid();
    chk("t5_bp_s_rready", S_RREADY, 1'b0);
    chk("t5_bp_rvalid", {M0_RVALID, M1_RVALID}, 2'b01);
    cyc(); S_RVALID = 1'b0; M1_RREADY = 1'b1;

    // reset during ADDR with 2 outstanding
    do_reset();
    S_ARREADY = 1'b1; M1_ARVALID = 1'b1;
    cyc(); M1_ARVALID = 1'b0;
    cyc(); M0_ARVALID = 1'b1;
    cyc(); M0_ARVALID = 1'b0;
    cyc(); S_ARREADY = 1'b0; M0_ARVALID = 1'b1;
    cyc(); M0_ARVALID = 1'b0; ARESET = 1'b1; S_ARREADY = 1'b1;
    mid();
    chk("t6_pre_count", dut.count_q, 2);
    chk("t6_pre_arvalid", S_ARVALID, 1'b1);
    cyc(); ARESET = 1'b0; S_ARREADY = 1'b0; M0_ARVALID = 1'b1; M1_ARVALID = 1'b1;
    mid();
    chk("t6_post_arvalid", S_ARVALID, 1'b0);
    chk("t6_post_count", dut.count_q, 0);
    chk("t6_first_tie", {M0_ARREADY, M1_ARREADY}, 2'b10);
    cyc();
    idle_in();

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      cyc();
      ARESET     = ($urandom_range(0, 299) == 0);
      M0_ARVALID = ($urandom_range(0, 2) != 0);
      M1_ARVALID = ($urandom_range(0, 2) != 0);
      M0_ARID = 1'($urandom); M1_ARID = 1'($urandom);
      M0_ARADDR = $urandom; M1_ARADDR = $urandom;
      M0_ARLEN = 4'($urandom); M1_ARLEN = 4'($urandom);
      M0_ARSIZE = 2'($urandom); M1_ARSIZE = 2'($urandom);
      M0_ARBURST = 2'($urandom); M1_ARBURST = 2'($urandom);
      S_ARREADY = ($urandom_range(0, 2) != 0);
      S_RVALID  = ($urandom_range(0, 1) != 0);
      S_RLAST   = ($urandom_range(0, 2) == 0);
      S_RID = 1'($urandom); S_RDATA = $urandom; S_RRESP = 2'($urandom);
      M0_RREADY = ($urandom_range(0, 3) != 0);
      M1_RREADY = ($urandom_range(0, 3) != 0);
    end
    cyc();
    idle_in();
    mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
